// File: rtl/move_pkg.sv
// Direction encoding and reset directions shared by the move controller and the game stage.
package move_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam dir_t P1_RESET_DIR = DOWN;
    localparam dir_t P2_RESET_DIR = UP;

    // Presses are ordered {up, down, left, right}; no press keeps the held direction.
    function automatic dir_t encode_press(input logic [3:0] press, input dir_t held);
        if (press[3])      return UP;
        else if (press[2]) return DOWN;
        else if (press[1]) return LEFT;
        else if (press[0]) return RIGHT;
        else               return held;
    endfunction

endpackage

// File: rtl/move_controller_if.sv
// Button inputs and direction outputs between the board I/O side and the move controller.
interface move_controller_if;

    logic [3:0] btn1;
    logic [3:0] btn2;
    logic [3:0] yon;
    logic       step;

    modport master (output btn1, output btn2, input yon, input step);
    modport slave  (input btn1, input btn2, output yon, output step);

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Level flips on the edge that completes DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync1 == level) begin
            count <= '0;
        end else if (count == COUNT_LAST) begin
            count <= '0;
            level <= sync1;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/move_controller.sv
// Debounces both players' buttons, latches the latest pressed direction and publishes it on each tick.
module move_controller
    import move_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_CYCLES     = 8
) (
    input logic             clk,
    input logic             rst,
    move_controller_if.slave bus
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [7:0]    raw;
    logic [7:0]    level;
    logic [7:0]    level_q;
    logic [7:0]    press;
    dir_t          pending1;
    dir_t          pending2;
    dir_t          pending1_next;
    dir_t          pending2_next;
    logic [TW-1:0] tick;
    logic          wrap;
    logic [3:0]    yon_q;
    logic          step_q;

    assign raw = {bus.btn1, bus.btn2};

    for (genvar i = 0; i < 8; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(level[i])
        );
    end

    assign press = level & ~level_q;
    assign wrap  = (tick == TICK_LAST);

    always_comb begin
        pending1_next = encode_press(press[7:4], pending1);
        pending2_next = encode_press(press[3:0], pending2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= '0;
            pending1 <= P1_RESET_DIR;
            pending2 <= P2_RESET_DIR;
        end else begin
            level_q  <= level;
            pending1 <= pending1_next;
            pending2 <= pending2_next;
        end
    end

    // yon samples pending before this edge, so a press landing on a wrap waits one more tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick   <= '0;
            step_q <= 1'b0;
            yon_q  <= {P1_RESET_DIR, P2_RESET_DIR};
        end else begin
            tick   <= wrap ? '0 : tick + TW'(1);
            step_q <= wrap;
            if (wrap) begin
                yon_q <= {pending1, pending2};
            end
        end
    end

    assign bus.yon  = yon_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with DEBOUNCE_CYCLES=4 and TICK_CYCLES=8.
module tb_move_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    move_controller_if mc_if ();

    move_controller #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mc_if)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: edge k after release leaves cyc == k.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_output(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] b1, input logic [3:0] b2);
        mc_if.btn1 = b1;
        mc_if.btn2 = b2;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_output("reset_yon", mc_if.yon, 4'b0100);
        check_output("reset_step", {3'b000, mc_if.step}, 4'b0000);
    endtask

    // Steps to cycle 'target', checking that step fires only on multiples of 8.
    task automatic advance_to(input int target);
        int guard = 0;
        while (cyc < target && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            check_output($sformatf("step_c%0d", cyc), {3'b000, mc_if.step},
                         {3'b000, (cyc % 8 == 0)});
        end
        check_output($sformatf("reach_c%0d", target), {3'b000, (cyc == target)}, 4'b0001);
    endtask

    initial begin
        apply_stimulus(4'b0000, 4'b0000);

        // Idle: steps at 8, 16, 24 with the reset directions.
        apply_reset();
        advance_to(8);
        check_output("idle_yon_8", mc_if.yon, 4'b0100);
        advance_to(16);
        check_output("idle_yon_16", mc_if.yon, 4'b0100);
        advance_to(24);
        check_output("idle_yon_24", mc_if.yon, 4'b0100);

        // Player 1 LEFT from cycle 2: pending at edge 9, visible on the cycle-16 step.
        apply_reset();
        advance_to(2);
        apply_stimulus(4'b0010, 4'b0000);
        advance_to(8);
        check_output("left_yon_8", mc_if.yon, 4'b0100);
        advance_to(16);
        check_output("left_yon_16", mc_if.yon, 4'b1000);
        apply_stimulus(4'b0000, 4'b0000);

        // Three-cycle glitch is ignored; a four-cycle pulse is accepted.
        apply_reset();
        advance_to(2);
        apply_stimulus(4'b0000, 4'b0001);
        advance_to(5);
        apply_stimulus(4'b0000, 4'b0000);
        advance_to(8);
        check_output("glitch_yon_8", mc_if.yon, 4'b0100);
        advance_to(16);
        check_output("glitch_yon_16", mc_if.yon, 4'b0100);
        apply_stimulus(4'b0000, 4'b0001);
        advance_to(20);
        apply_stimulus(4'b0000, 4'b0000);
        advance_to(24);
        check_output("pulse4_yon_24", mc_if.yon, 4'b0111);

        // Simultaneous presses: priority within a player, both players captured, releases ignored.
        apply_reset();
        advance_to(2);
        apply_stimulus(4'b1111, 4'b0110);
        advance_to(8);
        check_output("prio_yon_8", mc_if.yon, 4'b0100);
        advance_to(16);
        check_output("prio_yon_16", mc_if.yon, 4'b0001);
        apply_stimulus(4'b0000, 4'b0000);
        advance_to(24);
        check_output("release_yon_24", mc_if.yon, 4'b0001);

        // P2 LEFT lands on pending at edge 15, P1 RIGHT exactly on the wrap edge 16.
        apply_reset();
        advance_to(8);
        apply_stimulus(4'b0000, 4'b0010);
        advance_to(9);
        apply_stimulus(4'b0001, 4'b0010);
        advance_to(16);
        check_output("wrap_yon_16", mc_if.yon, 4'b0110);
        advance_to(24);
        check_output("wrap_yon_24", mc_if.yon, 4'b1110);
        apply_stimulus(4'b0000, 4'b0000);

        // Reset on a wrap cycle with UP pending; the held button re-registers after release.
        apply_reset();
        advance_to(2);
        apply_stimulus(4'b1000, 4'b0000);
        advance_to(8);
        check_output("rstwrap_yon_8", mc_if.yon, 4'b0100);
        advance_to(15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("rstwrap_step", {3'b000, mc_if.step}, 4'b0000);
        check_output("rstwrap_yon", mc_if.yon, 4'b0100);
        rst = 1'b0;
        advance_to(8);
        check_output("held_yon_8", mc_if.yon, 4'b0000);
        advance_to(16);
        check_output("held_yon_16", mc_if.yon, 4'b0000);
        apply_stimulus(4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
